// File: rtl/pll_supervisor_pkg.sv
// Shared types and counter-width helpers for the PLL lock supervisor.
package pll_supervisor_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } ch_state_e;

  // Bits needed to hold values 0..n-1, never narrower than one bit.
  function automatic int bits_for(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int timer_w(input int lock_timeout, input int reset_cycles);
    return bits_for((lock_timeout > reset_cycles) ? lock_timeout : reset_cycles);
  endfunction

  function automatic int stable_w(input int stable_cycles);
    return bits_for(stable_cycles + 1);
  endfunction

  function automatic int retry_w(input int max_retries);
    return bits_for(max_retries + 1);
  endfunction

endpackage

// File: rtl/pll_supervisor_ch.sv
// One supervisor channel: LOCK synchroniser, reset/lock FSM, retry and relock counters.
module pll_supervisor_ch
  import pll_supervisor_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pll_lock_i,
  input  logic             force_reset_i,
  input  logic             clear_fault_i,
  output logic             pll_resetb_o,
  output logic             ready_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] relock_count_o
);

  localparam int TMR_W = timer_w(LOCK_TIMEOUT, RESET_CYCLES);
  localparam int STB_W = stable_w(STABLE_CYCLES);
  localparam int RTY_W = retry_w(MAX_RETRIES);

  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(RESET_CYCLES - 1);
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_DONE  = STB_W'(STABLE_CYCLES);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRIES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  ch_state_e        state_q,  state_d;
  logic [TMR_W-1:0] timer_q,  timer_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [RTY_W-1:0] retry_q,  retry_d;
  logic [CNT_W-1:0] relock_q, relock_d;
  logic [RTY_W-1:0] retry_inc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      state_q  <= HOLD;
      timer_q  <= '0;
      stable_q <= '0;
      retry_q  <= '0;
      relock_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pll_lock_i};
      state_q  <= state_d;
      timer_q  <= timer_d;
      stable_q <= stable_d;
      retry_q  <= retry_d;
      relock_q <= relock_d;
    end
  end

  assign lock_s    = sync_q[SYNC_STAGES-1];
  assign retry_inc = retry_q + RTY_W'(1);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    stable_d = stable_q;
    retry_d  = retry_q;
    relock_d = relock_q;

    // Every path into HOLD clears the timer so the reset pulse is always full length.
    if (force_reset_i) begin
      state_d = HOLD;
      timer_d = '0;
      retry_d = '0;
    end else if (clear_fault_i && (state_q == FAULT)) begin
      state_d = HOLD;
      timer_d = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (timer_q == HOLD_LAST) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d  = STABLE;
            stable_d = STB_W'(1);
            timer_d  = '0;
          end else if (timer_q == WAIT_LAST) begin
            timer_d = '0;
            retry_d = retry_inc;
            state_d = (retry_inc == RTY_MAX) ? FAULT : HOLD;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end else if (stable_q == STB_DONE) begin
            state_d = RUN;
            retry_d = '0;
          end else begin
            stable_d = stable_q + STB_W'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_d = HOLD;
            timer_d = '0;
            retry_d = '0;
            if (relock_q != '1) relock_d = relock_q + CNT_W'(1);
          end
        end
        FAULT: ;
        default: begin
          state_d = HOLD;
          timer_d = '0;
        end
      endcase
    end
  end

  assign pll_resetb_o   = !((state_q == HOLD) || (state_q == FAULT));
  assign ready_o        = (state_q == RUN);
  assign fault_o        = (state_q == FAULT);
  assign relock_count_o = relock_q;

endmodule

// File: rtl/pll_supervisor.sv
// Lock supervisor for NUM_PLL independent PLLs on the reference clock.
module pll_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int NUM_PLL       = 1,
  parameter int SYNC_STAGES   = 2,
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 8
) (
  input  logic                       clock_in,
  input  logic                       reset_n,
  input  logic [NUM_PLL-1:0]         pll_lock,
  input  logic [NUM_PLL-1:0]         force_reset,
  input  logic                       clear_fault,
  output logic [NUM_PLL-1:0]         pll_resetb,
  output logic [NUM_PLL-1:0]         ch_ready,
  output logic [NUM_PLL-1:0]         ch_fault,
  output logic                       all_ready,
  output logic [NUM_PLL*CNT_W-1:0]   relock_count
);

  for (genvar i = 0; i < NUM_PLL; i++) begin : g_ch
    pll_supervisor_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .RESET_CYCLES (RESET_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .STABLE_CYCLES(STABLE_CYCLES),
      .MAX_RETRIES  (MAX_RETRIES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk_i         (clock_in),
      .rst_ni        (reset_n),
      .pll_lock_i    (pll_lock[i]),
      .force_reset_i (force_reset[i]),
      .clear_fault_i (clear_fault),
      .pll_resetb_o  (pll_resetb[i]),
      .ready_o       (ch_ready[i]),
      .fault_o       (ch_fault[i]),
      .relock_count_o(relock_count[i*CNT_W +: CNT_W])
    );
  end

  assign all_ready = &ch_ready;

endmodule

// File: tb/tb_pll_supervisor.sv
// Scoreboard bench for pll_supervisor: directed scenarios then random lock/force/clear traffic.
module tb_pll_supervisor;

  localparam int NUM_PLL       = 2;
  localparam int SYNC_STAGES   = 2;
  localparam int RESET_CYCLES  = 4;
  localparam int LOCK_TIMEOUT  = 32;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int CNT_W         = 2;
  localparam int RL_MAX        = (1 << CNT_W) - 1;

  localparam int M_HOLD = 0, M_WAIT = 1, M_STAB = 2, M_RUN = 3, M_FAULT = 4;

  logic                     clock_in = 1'b0;
  logic                     reset_n;
  logic [NUM_PLL-1:0]       pll_lock, force_reset;
  logic                     clear_fault;
  logic [NUM_PLL-1:0]       pll_resetb, ch_ready, ch_fault;
  logic                     all_ready;
  logic [NUM_PLL*CNT_W-1:0] relock_count;

  always #5 clock_in = ~clock_in;

  pll_supervisor #(
    .NUM_PLL(NUM_PLL), .SYNC_STAGES(SYNC_STAGES), .RESET_CYCLES(RESET_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES(MAX_RETRIES), .CNT_W(CNT_W)
  ) dut (
    .clock_in(clock_in), .reset_n(reset_n), .pll_lock(pll_lock),
    .force_reset(force_reset), .clear_fault(clear_fault),
    .pll_resetb(pll_resetb), .ch_ready(ch_ready), .ch_fault(ch_fault),
    .all_ready(all_ready), .relock_count(relock_count)
  );

  typedef struct packed {
    logic [NUM_PLL-1:0]       resetb;
    logic [NUM_PLL-1:0]       ready;
    logic [NUM_PLL-1:0]       fault;
    logic                     all;
    logic [NUM_PLL*CNT_W-1:0] relock;
  } obs_t;

  obs_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel is a phase plus elapsed-time counters.
  int mph[NUM_PLL], mtime[NUM_PLL], mstab[NUM_PLL], mretry[NUM_PLL], mrelock[NUM_PLL];
  logic [NUM_PLL-1:0] lock_hist[$];

  function automatic void model_reset();
    for (int c = 0; c < NUM_PLL; c++) begin
      mph[c] = M_HOLD; mtime[c] = 0; mstab[c] = 0; mretry[c] = 0; mrelock[c] = 0;
    end
    lock_hist.delete();
    for (int s = 0; s < SYNC_STAGES; s++) lock_hist.push_back('0);
  endfunction

  function automatic void model_step(input logic [NUM_PLL-1:0] lk, input logic [NUM_PLL-1:0] fr,
                                     input logic cf);
    logic [NUM_PLL-1:0] ls;
    ls = lock_hist.pop_front();
    lock_hist.push_back(lk);
    for (int c = 0; c < NUM_PLL; c++) begin
      if (fr[c] || (cf && mph[c] == M_FAULT)) begin
        mph[c] = M_HOLD; mtime[c] = 0; mretry[c] = 0;
      end else if (mph[c] == M_HOLD) begin
        if (mtime[c] == RESET_CYCLES - 1) begin mph[c] = M_WAIT; mtime[c] = 0; end
        else mtime[c]++;
      end else if (mph[c] == M_WAIT) begin
        if (ls[c]) begin mph[c] = M_STAB; mstab[c] = 1; end
        else if (mtime[c] == LOCK_TIMEOUT - 1) begin
          mretry[c]++;
          mtime[c] = 0;
          mph[c] = (mretry[c] == MAX_RETRIES) ? M_FAULT : M_HOLD;
        end else mtime[c]++;
      end else if (mph[c] == M_STAB) begin
        if (!ls[c]) begin mph[c] = M_WAIT; mtime[c] = 0; end
        else if (mstab[c] == STABLE_CYCLES) begin mph[c] = M_RUN; mretry[c] = 0; end
        else mstab[c]++;
      end else if (mph[c] == M_RUN) begin
        if (!ls[c]) begin
          mph[c] = M_HOLD; mtime[c] = 0; mretry[c] = 0;
          if (mrelock[c] < RL_MAX) mrelock[c]++;
        end
      end
    end
  endfunction

  function automatic obs_t model_out();
    obs_t e;
    for (int c = 0; c < NUM_PLL; c++) begin
      e.resetb[c] = !(mph[c] == M_HOLD || mph[c] == M_FAULT);
      e.ready[c]  = (mph[c] == M_RUN);
      e.fault[c]  = (mph[c] == M_FAULT);
      e.relock[c*CNT_W +: CNT_W] = CNT_W'(mrelock[c]);
    end
    e.all = &e.ready;
    return e;
  endfunction

  always @(negedge clock_in) begin
    if (sb_q.size() > 0) begin
      obs_t e, a;
      e = sb_q.pop_front();
      a = {pll_resetb, ch_ready, ch_fault, all_ready, relock_count};
      check("cycle_outputs", 32'(a), 32'(e));
    end
  end

  task automatic step(input logic [NUM_PLL-1:0] lk, input logic [NUM_PLL-1:0] fr, input logic cf);
    pll_lock = lk; force_reset = fr; clear_fault = cf;
    @(posedge clock_in);
    model_step(lk, fr, cf);
    sb_q.push_back(model_out());
    #1;
  endtask

  task automatic bringup_check(input string tag);
    int rb_edge, rdy_edge;
    rb_edge = -1; rdy_edge = -1;
    pll_lock = 2'b11; force_reset = '0; clear_fault = 1'b0;
    @(negedge clock_in);
    #2 reset_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step(2'b11, 2'b00, 1'b0);
      if (rb_edge < 0 && pll_resetb == 2'b11) rb_edge = k;
      if (rdy_edge < 0 && all_ready) rdy_edge = k;
    end
    check({tag, "_resetb_release_edge"}, rb_edge, 4);
    check({tag, "_all_ready_edge"}, rdy_edge, 13);
    check({tag, "_ready_both"}, ch_ready, 2'b11);
    check({tag, "_relock_zero"}, relock_count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_k, rb0_low;
    int hold_left[NUM_PLL];
    logic [NUM_PLL-1:0] lvl;

    reset_n = 1'b0; pll_lock = 2'b11; force_reset = '0; clear_fault = 1'b0;
    model_reset();
    #12;
    check("reset_state", {pll_resetb, ch_ready, ch_fault, all_ready, relock_count}, 0);

    bringup_check("s1");

    // Channel 1 never locks: two retries then FAULT, channel 0 keeps running.
    for (int k = 0; k < 100; k++) step(2'b01, 2'b00, 1'b0);
    check("s2_ch_fault", ch_fault, 2'b10);
    check("s2_ch1_resetb", pll_resetb[1], 1'b0);
    check("s2_ch0_ready", ch_ready[0], 1'b1);
    step(2'b01, 2'b00, 1'b1);
    check("s2_fault_cleared", ch_fault, 2'b00);
    check("s2_ch1_hold", pll_resetb[1], 1'b0);

    // Lock glitch after five stable cycles restarts the stable count.
    step(2'b01, 2'b01, 1'b0);
    for (int k = 0; k < 9; k++) step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);
    first_k = -1; rb0_low = 0;
    for (int k = 1; k <= 30; k++) begin
      step(2'b01, 2'b00, 1'b0);
      if (!pll_resetb[0]) rb0_low++;
      if (first_k < 0 && ch_ready[0]) first_k = k;
    end
    check("s3_glitch_ready_edge", first_k, 11);
    check("s3_resetb_low_cycles", rb0_low, 0);

    // Repeated lock loss in RUN: fast ready drop and saturating relock counter.
    for (int d = 0; d < 4; d++) begin
      first_k = -1;
      for (int k = 1; k <= 6; k++) begin
        step(2'b00, 2'b00, 1'b0);
        if (first_k < 0 && !ch_ready[0]) first_k = k;
      end
      check("s4_ready_drop_edge", first_k, 3);
      check("s4_relock_count", relock_count[CNT_W-1:0], (d + 1 > RL_MAX) ? RL_MAX : d + 1);
      for (int k = 0; k < 30; k++) step(2'b01, 2'b00, 1'b0);
      check("s4_relocked", ch_ready[0], 1'b1);
    end

    check("s5_ch1_fault_before", ch_fault[1], 1'b1);
    step(2'b01, 2'b01, 1'b0);
    check("s5_ch0_resetb", pll_resetb[0], 1'b0);
    check("s5_all_ready", all_ready, 1'b0);
    check("s5_ch1_fault_kept", ch_fault[1], 1'b1);
    check("s5_relock_kept", relock_count[CNT_W-1:0], RL_MAX);
    for (int k = 0; k < 7; k++) step(2'b01, 2'b00, 1'b0);

    // Asynchronous reset between edges while channel 0 is in STABLE.
    #5 reset_n = 1'b0;
    #1;
    check("s6_async_reset", {pll_resetb, ch_ready, ch_fault, all_ready, relock_count}, 0);
    sb_q.delete();
    model_reset();
    @(posedge clock_in);
    bringup_check("s6");

    for (int c = 0; c < NUM_PLL; c++) hold_left[c] = 0;
    lvl = 2'b11;
    for (int n = 0; n < 3000; n++) begin
      logic [NUM_PLL-1:0] fr;
      for (int c = 0; c < NUM_PLL; c++) begin
        if (hold_left[c] == 0) begin
          lvl[c] = ($urandom_range(0, 3) != 0);
          hold_left[c] = lvl[c] ? $urandom_range(5, 120) : $urandom_range(1, 90);
        end else hold_left[c]--;
        fr[c] = ($urandom_range(0, 299) == 0);
      end
      step(lvl, fr, $urandom_range(0, 149) == 0);
    end

    @(negedge clock_in);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_supervisor.md
Name: pll_supervisor

Overview:
- Parametrised lock supervisor for NUM_PLL iCE40 SB_PLL40 instances. One supervisor channel per PLL.
- Each channel drives the PLL RESETB and synchronises the raw LOCK.
- Lock must be stable for a programmed time before the channel's ready is raised.
- A lock timeout triggers a retry reset pulse; repeated failures latch a fault.
- Runs on the board reference clock, which is independent of the PLL outputs. ready/fault feed the reset and status logic of the PLL output domains.

Parameters:
- NUM_PLL, 1: number of supervised PLLs (1..8).
- SYNC_STAGES, 2: synchroniser depth on each pll_lock bit (>=2).
- RESET_CYCLES, 16: cycles RESETB is held low per reset pulse (>=1).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before a retry.
- STABLE_CYCLES, 1024: consecutive synchronised-high lock cycles required before ready.
- MAX_RETRIES, 3: consecutive lock timeouts before FAULT (>=1).
- CNT_W, 8: width of each relock counter.

Ports:
- clock_in, in, 1: reference clock; the only clock.
- reset_n, in, 1: asynchronous, active-low reset.
- pll_lock, in, NUM_PLL: raw LOCK from each PLL (asynchronous).
- force_reset, in, NUM_PLL: per-channel synchronous request to restart the channel.
- clear_fault, in, 1: synchronous pulse that clears every channel in FAULT.
- pll_resetb, out, NUM_PLL: drives PLL RESETB; 0 holds the PLL in reset.
- ch_ready, out, NUM_PLL: channel locked and stable.
- ch_fault, out, NUM_PLL: sticky; retries exhausted.
- all_ready, out, 1: AND of ch_ready.
- relock_count, out, NUM_PLL*CNT_W: per-channel count of lock losses from RUN. Saturating. Channel i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset (reset_n=0, async):
  - every channel in HOLD, with timer, stable count, retry count and relock_count all 0;
  - synchroniser flops 0;
  - pll_resetb=0, ch_ready=0, ch_fault=0, all_ready=0.
- lock_s[i]: pll_lock[i] passed through SYNC_STAGES flops. All state decisions use lock_s only.
- HOLD:
  - pll_resetb=0.
  - Timer counts 0..RESET_CYCLES-1; on the last count go to WAIT_LOCK with the timer cleared.
- WAIT_LOCK:
  - pll_resetb=1.
  - lock_s=1: go to STABLE, stable count=1.
  - Otherwise, timer reaches LOCK_TIMEOUT-1: retries+1. If the new retries equals MAX_RETRIES go to FAULT, else go to HOLD.
- STABLE:
  - pll_resetb=1.
  - lock_s=1: stable count+1. On reaching STABLE_CYCLES go to RUN.
  - lock_s=0: go to WAIT_LOCK with the timer cleared; retries unchanged.
- RUN:
  - pll_resetb=1, ch_ready=1.
  - lock_s=0: go to HOLD, retries=0, relock_count+1 saturating at 2^CNT_W-1.
- FAULT:
  - pll_resetb=0, ch_fault=1.
  - Stays in FAULT until clear_fault, then goes to HOLD with retries=0.
- Output timing: ch_ready and ch_fault are decoded from registered state with no extra flop. all_ready is the combinational AND of ch_ready.
- Priority per channel: force_reset[i] > clear_fault > normal transitions.
  - force_reset from any state: go to HOLD, timer and retries cleared, relock_count unchanged, ch_fault cleared.
  - force_reset held high keeps the channel in HOLD.
- Retries reset to 0 on entering RUN.
- Latency, from a lock_s rising edge in WAIT_LOCK: ch_ready rises exactly STABLE_CYCLES edges later.
- Latency, from a pll_lock falling edge in RUN: ch_ready falls within SYNC_STAGES+1 edges.
- Width rules:
  - timer width is clog2 of the larger of LOCK_TIMEOUT and RESET_CYCLES;
  - stable count width is clog2(STABLE_CYCLES+1);
  - retry width is clog2(MAX_RETRIES+1);
  - no counter wraps.
- Channels are fully independent apart from the shared clear_fault and all_ready.

Decomposition:
- Package pll_supervisor_pkg:
  - state enum {HOLD, WAIT_LOCK, STABLE, RUN, FAULT};
  - clog2-derived width constants.
- Sub-module pll_supervisor_ch holds one synchroniser, one FSM and its counters. The top level instantiates NUM_PLL copies in a generate loop and forms all_ready.

Test Plan (RESET_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2, CNT_W=2, NUM_PLL=2 unless stated):
1. Release reset with pll_lock=2'b11 steady -> pll_resetb=0 for 4 edges, then 1. ch_ready=2'b11 and all_ready=1 rise 13 edges after release (4 HOLD + 1 WAIT_LOCK + 8 STABLE); relock_count=0.
2. pll_lock[1]=0 forever -> pll_resetb[1] gives two low pulses of 4 cycles separated by 32 cycles high, then stays 0 with ch_fault[1]=1. One clear_fault pulse -> ch_fault[1]=0 and a new 4-cycle HOLD; channel 0 unaffected throughout.
3. A 1-cycle low glitch on pll_lock[0] after 5 stable cycles -> ch_ready[0] is delayed by the full restart (8 more stable cycles after lock_s returns); no retry is counted and pll_resetb stays 1.
4. In RUN, drop pll_lock[0] four times, each followed by relock -> ch_ready[0] falls within 3 edges each time. relock_count[1:0] reads 1, 2, 3, 3 (saturated).
5. force_reset[0] pulse while ch0 in RUN and ch1 in FAULT -> ch0 goes to HOLD (4-cycle pll_resetb pulse, relock_count unchanged); ch1 remains in FAULT; all_ready=0.
6. Assert reset_n mid-STABLE, asynchronously between edges -> all outputs go to their reset values immediately, with no clock edge; after release the sequence of scenario 1 repeats exactly.
